// File: rtl/stream_arbiter.sv
// Round-robin stream arbiter with burst lock and a registered output stage.
// N producers share one sink; each output beat carries the index of its source.
module stream_arbiter #(
  parameter type T         = logic [7:0],
  parameter int  N         = 4,
  parameter int  MAX_BURST = 2,
  localparam int IW        = (N > 1) ? $clog2(N) : 1,
  localparam int CW        = $clog2(MAX_BURST + 1)
) (
  input  logic          clock,
  input  logic          reset,
  input  logic [N-1:0]  receiver_valid,
  output logic [N-1:0]  receiver_ready,
  input  T     [N-1:0]  receiver_data,
  output logic          sender_valid,
  input  logic          sender_ready,
  output T              sender_data,
  output logic [IW-1:0] sender_source
);

  // Output stage and arbitration state
  logic          r_valid;
  T              r_data;
  logic [IW-1:0] r_source;
  logic [IW-1:0] r_pointer;   // last granted requester; search starts just after it
  logic [IW-1:0] r_owner;     // requester holding the current burst
  logic [CW-1:0] r_burst;     // beats granted to r_owner in the current burst

  logic          w_load;
  logic          w_lock;
  logic          w_any;
  logic          w_accept;
  logic          w_found;
  logic [IW-1:0] w_search;
  logic [IW-1:0] w_grant;

  // Output register can take a beat when empty or draining this cycle
  assign w_load = !r_valid || sender_ready;

  // Owner keeps the grant while its burst is open and it still has data
  assign w_lock = (r_burst != '0) && (r_burst < CW'(MAX_BURST)) && receiver_valid[r_owner];

  // Round-robin search: pointer+1, pointer+2, ... wrapping, pointer itself last
  always_comb begin
    w_found  = 1'b0;
    w_search = '0;
    for (int k = 1; k <= N; k++) begin
      if (!w_found && receiver_valid[(int'(r_pointer) + k) % N]) begin
        w_found  = 1'b1;
        w_search = IW'((int'(r_pointer) + k) % N);
      end
    end
  end

  assign w_grant  = w_lock ? r_owner : w_search;
  assign w_any    = w_lock || (|receiver_valid);
  assign w_accept = w_load && w_any;

  // One-hot ready toward the granted producer; forced low while in reset
  generate
    for (genvar gi = 0; gi < N; gi++) begin : g_ready
      assign receiver_ready[gi] = reset && w_accept && (w_grant == IW'(gi));
    end
  endgenerate

  // Output stage load, grant bookkeeping and burst counting
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_valid   <= 1'b0;
      r_data    <= '0;
      r_source  <= '0;
      r_pointer <= IW'(N - 1);
      r_owner   <= '0;
      r_burst   <= '0;
    end else if (w_load) begin
      if (w_any) begin
        r_valid   <= 1'b1;
        r_data    <= receiver_data[w_grant];
        r_source  <= w_grant;
        r_pointer <= w_grant;
        r_owner   <= w_grant;
        // lock implies r_burst < MAX_BURST, so the increment never wraps
        r_burst   <= w_lock ? (r_burst + CW'(1)) : CW'(1);
      end else begin
        r_valid   <= 1'b0;
        r_burst   <= '0;
      end
    end
  end

  assign sender_valid  = r_valid;
  assign sender_data   = r_data;
  assign sender_source = r_source;

endmodule

// File: tb/tb_stream_arbiter.sv
// Directed bench for stream_arbiter (N=4, 8-bit payload, MAX_BURST=2).
module tb_stream_arbiter;

  logic             clock;
  logic             reset;
  logic [3:0]       receiver_valid;
  logic [3:0]       receiver_ready;
  logic [3:0][7:0]  receiver_data;
  logic             sender_valid;
  logic             sender_ready;
  logic [7:0]       sender_data;
  logic [1:0]       sender_source;

  int errors = 0;
  int checks = 0;

  // Producer models: requester i offers base[i]+cnt[i] while enabled and below its beat limit
  logic [3:0] en;
  logic [7:0] base [4];
  int         limit [4];
  int         cnt [4];
  logic       tb_clr;

  stream_arbiter #(.T(logic [7:0]), .N(4), .MAX_BURST(2)) dut (
    .clock          (clock),
    .reset          (reset),
    .receiver_valid (receiver_valid),
    .receiver_ready (receiver_ready),
    .receiver_data  (receiver_data),
    .sender_valid   (sender_valid),
    .sender_ready   (sender_ready),
    .sender_data    (sender_data),
    .sender_source  (sender_source)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  always_comb begin
    for (int i = 0; i < 4; i++) begin
      receiver_valid[i] = en[i] && (cnt[i] < limit[i]);
      receiver_data[i]  = base[i] + 8'(cnt[i]);
    end
  end

  always @(posedge clock) begin
    for (int i = 0; i < 4; i++) begin
      if (tb_clr) cnt[i] <= 0;
      else if (receiver_valid[i] && receiver_ready[i]) cnt[i] <= cnt[i] + 1;
    end
  end

  task automatic clear_counters();
    tb_clr = 1'b1;
    @(posedge clock); #1;
    tb_clr = 1'b0;
  endtask

  task automatic set_bases(input logic [7:0] b0, input logic [7:0] b1,
                           input logic [7:0] b2, input logic [7:0] b3);
    base[0] = b0; base[1] = b1; base[2] = b2; base[3] = b3;
  endtask

  task automatic test_reset();
    // checks while reset is held
    checks++;
    if (sender_valid !== 1'b0 || receiver_ready !== 4'b0000 || sender_source !== 2'd0) begin
      errors++;
      $display("FAIL reset_hold: valid=%b ready=%b src=%0d required valid=0 ready=0000 src=0",
               sender_valid, receiver_ready, sender_source);
    end
    @(posedge clock); #3;
    reset = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(posedge clock); #1;
      checks++;
      if (sender_valid !== 1'b0 || receiver_ready !== 4'b0000 || sender_source !== 2'd0) begin
        errors++;
        $display("FAIL idle_after_reset cyc%0d: valid=%b ready=%b src=%0d required 0/0000/0",
                 c, sender_valid, receiver_ready, sender_source);
      end
    end
    $display("test_reset done");
  endtask

  task automatic test_round_robin();
    logic [1:0] exp_src [10] = '{0, 0, 1, 1, 2, 2, 3, 3, 0, 0};
    logic [7:0] exp_dat [10] = '{8'h00, 8'h01, 8'h10, 8'h11, 8'h20, 8'h21, 8'h30, 8'h31, 8'h02, 8'h03};
    set_bases(8'h00, 8'h10, 8'h20, 8'h30);
    clear_counters();
    en = 4'b1111;
    for (int k = 0; k < 10; k++) begin
      @(posedge clock); #1;
      checks++;
      if (sender_valid !== 1'b1 || sender_source !== exp_src[k] || sender_data !== exp_dat[k]) begin
        errors++;
        $display("FAIL round_robin beat%0d: valid=%b src=%0d data=%02h required 1/%0d/%02h",
                 k, sender_valid, sender_source, sender_data, exp_src[k], exp_dat[k]);
      end
      $display("round_robin beat %0d src=%0d data=%02h", k, sender_source, sender_data);
    end
    en = 4'b0000;
    @(posedge clock); #1;
    checks++;
    if (sender_valid !== 1'b0) begin
      errors++;
      $display("FAIL round_robin_drain: valid=%b required 0", sender_valid);
    end
  endtask

  task automatic test_stall();
    logic [1:0] exp_src [8] = '{1, 1, 2, 2, 3, 3, 0, 0};
    logic [7:0] exp_dat [8] = '{8'h10, 8'h11, 8'h20, 8'h21, 8'h30, 8'h31, 8'h00, 8'h01};
    set_bases(8'h00, 8'h10, 8'h20, 8'h30);
    clear_counters();
    en = 4'b1111;
    for (int k = 0; k < 8; k++) begin
      @(posedge clock); #1;
      checks++;
      if (sender_valid !== 1'b1 || sender_source !== exp_src[k] || sender_data !== exp_dat[k]) begin
        errors++;
        $display("FAIL stall_stream beat%0d: valid=%b src=%0d data=%02h required 1/%0d/%02h",
                 k, sender_valid, sender_source, sender_data, exp_src[k], exp_dat[k]);
      end
      $display("stall_stream beat %0d src=%0d data=%02h", k, sender_source, sender_data);
      if (k == 2) begin
        sender_ready = 1'b0;
        for (int s = 0; s < 5; s++) begin
          @(posedge clock); #1;
          checks++;
          if (sender_valid !== 1'b1 || sender_data !== 8'h20 || sender_source !== 2'd2 ||
              receiver_ready !== 4'b0000) begin
            errors++;
            $display("FAIL stall_hold cyc%0d: valid=%b data=%02h src=%0d ready=%b required 1/20/2/0000",
                     s, sender_valid, sender_data, sender_source, receiver_ready);
          end
        end
        sender_ready = 1'b1;
      end
    end
    en = 4'b0000;
    @(posedge clock); #1;
  endtask

  task automatic test_single_requester();
    set_bases(8'h00, 8'h00, 8'hA0, 8'h00);
    limit[2] = 6;
    clear_counters();
    en = 4'b0100;
    for (int k = 0; k < 6; k++) begin
      @(posedge clock); #1;
      checks++;
      if (sender_valid !== 1'b1 || sender_source !== 2'd2 || sender_data !== 8'(8'hA0 + k)) begin
        errors++;
        $display("FAIL single_req beat%0d: valid=%b src=%0d data=%02h required 1/2/%02h",
                 k, sender_valid, sender_source, sender_data, 8'(8'hA0 + k));
      end
      $display("single_req beat %0d src=%0d data=%02h", k, sender_source, sender_data);
    end
    @(posedge clock); #1;
    checks++;
    if (sender_valid !== 1'b0) begin
      errors++;
      $display("FAIL single_req_end: valid=%b required 0", sender_valid);
    end
    en = 4'b0000;
    limit[2] = 1000;
  endtask

  task automatic test_owner_drop();
    // pointer is 2 here: requester 3 wins first, then 1 for one beat, then 3 restarts its burst
    logic [1:0] exp_src [5] = '{3, 3, 1, 3, 3};
    logic [7:0] exp_dat [5] = '{8'h30, 8'h31, 8'h10, 8'h32, 8'h33};
    set_bases(8'h00, 8'h10, 8'h00, 8'h30);
    limit[1] = 1;
    limit[3] = 4;
    clear_counters();
    en = 4'b1010;
    for (int k = 0; k < 5; k++) begin
      @(posedge clock); #1;
      checks++;
      if (sender_valid !== 1'b1 || sender_source !== exp_src[k] || sender_data !== exp_dat[k]) begin
        errors++;
        $display("FAIL owner_drop beat%0d: valid=%b src=%0d data=%02h required 1/%0d/%02h",
                 k, sender_valid, sender_source, sender_data, exp_src[k], exp_dat[k]);
      end
      $display("owner_drop beat %0d src=%0d data=%02h", k, sender_source, sender_data);
    end
    @(posedge clock); #1;
    checks++;
    if (sender_valid !== 1'b0) begin
      errors++;
      $display("FAIL owner_drop_end: valid=%b required 0", sender_valid);
    end
    en = 4'b0000;
    limit[1] = 1000;
    limit[3] = 1000;
  endtask

  task automatic test_async_reset();
    set_bases(8'h00, 8'h10, 8'h20, 8'h30);
    clear_counters();
    en = 4'b1111;
    @(posedge clock); #1;
    @(posedge clock); #1;
    checks++;
    if (sender_valid !== 1'b1 || sender_data !== 8'h01 || sender_source !== 2'd0) begin
      errors++;
      $display("FAIL pre_reset: valid=%b data=%02h src=%0d required 1/01/0",
               sender_valid, sender_data, sender_source);
    end
    #2;
    reset = 1'b0;
    #1;
    checks++;
    if (sender_valid !== 1'b0 || sender_data !== 8'h00 || sender_source !== 2'd0 ||
        receiver_ready !== 4'b0000) begin
      errors++;
      $display("FAIL async_reset: valid=%b data=%02h src=%0d ready=%b required 0/00/0/0000",
               sender_valid, sender_data, sender_source, receiver_ready);
    end
    tb_clr = 1'b1;
    @(posedge clock); #1;
    tb_clr = 1'b0;
    checks++;
    if (sender_valid !== 1'b0 || receiver_ready !== 4'b0000) begin
      errors++;
      $display("FAIL reset_held_edge: valid=%b ready=%b required 0/0000", sender_valid, receiver_ready);
    end
    reset = 1'b1;
    for (int k = 0; k < 2; k++) begin
      @(posedge clock); #1;
      checks++;
      if (sender_valid !== 1'b1 || sender_source !== 2'd0 || sender_data !== 8'(k)) begin
        errors++;
        $display("FAIL post_reset beat%0d: valid=%b src=%0d data=%02h required 1/0/%02h",
                 k, sender_valid, sender_source, sender_data, 8'(k));
      end
      $display("post_reset beat %0d src=%0d data=%02h", k, sender_source, sender_data);
    end
    en = 4'b0000;
    @(posedge clock); #1;
  endtask

  initial begin
    reset        = 1'b0;
    sender_ready = 1'b1;
    en           = 4'b0000;
    tb_clr       = 1'b1;
    for (int i = 0; i < 4; i++) begin
      base[i]  = 8'h00;
      limit[i] = 1000;
    end
    #1;
    test_reset();
    tb_clr = 1'b0;
    test_round_robin();
    test_stall();
    test_single_requester();
    test_owner_drop();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
